ntt_input_deserializer: RTL

Serial-to-parallel front end for the n=512, 128-lane NTT core. Accepts one coefficient per cycle over a valid/ready stream and assembles a full polynomial in a ping-pong buffer. Once a polynomial is complete, it bursts the polynomial into the core as four consecutive 128-lane vectors, with the core's replicated start strobes on the first vector. This lets the top level drive the core from a narrow port without IO-limited wide buses.

---
 rtl/ntt_pkg.sv | 26 ++
 rtl/ntt_input_deserializer_if.sv | 33 +++
 rtl/ntt_coeff_bank.sv | 36 +++
 rtl/ntt_input_deserializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ============================================================================
// Module   : ntt_pkg
// Purpose  : Shared constants, coefficient/vector types and drain states for
//            the n=512, 128-lane NTT core front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

  localparam int NTT_DATA_WIDTH = 28;
  localparam int NTT_LANES      = 128;
  localparam int NTT_N          = 512;
  localparam logic [NTT_DATA_WIDTH-1:0] NTT_Q = 28'd268369921;

  typedef logic [NTT_DATA_WIDTH-1:0] coeff_t;
  typedef coeff_t [NTT_LANES-1:0]    vec_t;

  typedef enum logic [0:0] {
    DRAIN_IDLE  = 1'b0,
    DRAIN_BURST = 1'b1
  } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/ntt_input_deserializer_if.sv
// ============================================================================
// Module   : ntt_input_deserializer_if
// Purpose  : Narrow coefficient input stream plus wide vector burst output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ntt_input_deserializer_if
  import ntt_pkg::*;
;
  logic       s_valid;
  logic       s_ready;
  coeff_t     s_data;
  logic       m_ready;
  logic       m_valid;
  coeff_t     m_data [NTT_LANES];
  logic [7:0] m_start;
  logic       err;

  // slave: the deserializer; master: whatever drives it
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_start, err
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_start, err
  );

endinterface

`default_nettype wire

// File: rtl/ntt_coeff_bank.sv
// ============================================================================
// Module   : ntt_coeff_bank
// Purpose  : One polynomial buffer: single-word write, whole-vector read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_coeff_bank #(
  parameter int DATA_WIDTH = 28,
  parameter int LANES      = 128,
  parameter int VECTORS    = 4,
  localparam int VEC_W     = $clog2(VECTORS),
  localparam int LANE_W    = $clog2(LANES)
) (
  input  wire logic                               clk,
  input  wire logic                               wr_en,
  input  wire logic [VEC_W-1:0]                   wr_vec,
  input  wire logic [LANE_W-1:0]                  wr_lane,
  input  wire logic [DATA_WIDTH-1:0]              wr_data,
  input  wire logic [VEC_W-1:0]                   rd_vec,
  output      logic [LANES-1:0][DATA_WIDTH-1:0]   rd_data
);

  logic [LANES-1:0][DATA_WIDTH-1:0] mem [VECTORS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_vec][wr_lane] <= wr_data;
    end
  end

  assign rd_data = mem[rd_vec];

endmodule

`default_nettype wire

// File: rtl/ntt_input_deserializer.sv
// ============================================================================
// Module   : ntt_input_deserializer
// Purpose  : Serial-to-parallel ping-pong front end; bursts each 512-word
//            polynomial into the NTT core as four 128-lane vectors.
//            Define NTT_DESER_MODCHECK_EN to reduce out-of-range inputs and
//            raise the sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_input_deserializer
  import ntt_pkg::*;
#(
  parameter int                    DATA_WIDTH = NTT_DATA_WIDTH,
  parameter int                    LANES      = NTT_LANES,
  parameter int                    VECTORS    = NTT_N / NTT_LANES,
  parameter logic [DATA_WIDTH-1:0] MODULUS    = NTT_Q
) (
  input wire logic                 clk,
  input wire logic                 rst,
  ntt_input_deserializer_if.slave  bus
);

  localparam int LANE_W = $clog2(LANES);
  localparam int VEC_W  = $clog2(VECTORS);
  localparam int K_W    = LANE_W + VEC_W;

  logic [1:0]            full;
  logic                  wr_bank;
  logic [K_W-1:0]        k;
  logic                  wr_hs;
  logic [DATA_WIDTH-1:0] wr_data;

  drain_state_t          state, state_nx;
  logic                  rd_bank, rd_bank_nx;
  logic [VEC_W-1:0]      v, v_nx;
  logic                  load;
  logic                  burst_done;

  logic [LANES-1:0][DATA_WIDTH-1:0] bank_rd [2];
  logic [LANES-1:0][DATA_WIDTH-1:0] out_data, m_data_r;
  logic [7:0]                       out_start, m_start_r;
  logic                             m_valid_r;

  assign bus.s_ready = !full[wr_bank];
  assign wr_hs       = bus.s_valid && bus.s_ready;

`ifdef NTT_DESER_MODCHECK_EN
  logic wr_oor;
  logic err_r;

  // MODULUS exceeds half the word range, so a single subtract always lands in [0, q)
  assign wr_oor  = bus.s_data >= MODULUS;
  assign wr_data = wr_oor ? bus.s_data - MODULUS : bus.s_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (wr_hs && wr_oor) begin
      err_r <= 1'b1;
    end
  end

  assign bus.err = err_r;
`else
  assign wr_data = bus.s_data;
  assign bus.err = 1'b0;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ntt_coeff_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .VECTORS    (VECTORS)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_hs && (wr_bank == 1'(b))),
      .wr_vec  (k[K_W-1:LANE_W]),
      .wr_lane (k[LANE_W-1:0]),
      .wr_data (wr_data),
      .rd_vec  (v_nx),
      .rd_data (bank_rd[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      wr_bank <= 1'b0;
    end else if (wr_hs) begin
      k <= k + 1'b1;
      if (&k) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Fill and drain always target opposite banks, so both updates may land together
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (wr_hs && (&k)) begin
        full[wr_bank] <= 1'b1;
      end
      if (burst_done) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    v_nx       = v;
    rd_bank_nx = rd_bank;
    load       = 1'b0;
    burst_done = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        if (full[rd_bank] && bus.m_ready) begin
          state_nx = DRAIN_BURST;
          v_nx     = '0;
          load     = 1'b1;
        end
      end
      DRAIN_BURST: begin
        if (v == VEC_W'(VECTORS - 1)) begin
          burst_done = 1'b1;
          rd_bank_nx = ~rd_bank;
          if (full[~rd_bank] && bus.m_ready) begin
            v_nx = '0;
            load = 1'b1;
          end else begin
            state_nx = DRAIN_IDLE;
          end
        end else begin
          v_nx = v + 1'b1;
          load = 1'b1;
        end
      end
      default: state_nx = DRAIN_IDLE;
    endcase
    out_data  = load ? bank_rd[rd_bank_nx] : '0;
    out_start = (load && (v_nx == '0)) ? 8'hFF : 8'h00;
  end

  // v always names the vector currently presented on the registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DRAIN_IDLE;
      v         <= '0;
      rd_bank   <= 1'b0;
      m_valid_r <= 1'b0;
      m_start_r <= 8'h00;
      m_data_r  <= '0;
    end else begin
      state     <= state_nx;
      v         <= v_nx;
      rd_bank   <= rd_bank_nx;
      m_valid_r <= load;
      m_start_r <= out_start;
      m_data_r  <= out_data;
    end
  end

  assign bus.m_valid = m_valid_r;
  assign bus.m_start = m_start_r;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign bus.m_data[l] = m_data_r[l];
  end

endmodule

`default_nettype wire
